// File: rtl/spi_ram_pkg.sv
// Shared types and defaults for the SPI RAM controller.
// Word width depends on the SPI_RAM_PARITY_EN macro (9 bits with parity, else 8).
package spi_ram_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DATA_W        = 8;

`ifdef SPI_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic {
    NO_ADDR = 1'b0,
    ADDR_OK = 1'b1
  } ptr_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port storage array: synchronous write, registered read port.
// The read register is the only part cleared by reset; array contents survive it.
module spi_ram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_addr,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_word,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_word
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_word;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_addr] <= i_wr_word;
  end

  // Read register holds its value between reads so the slave sees a stable byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rd_word <= '0;
    else if (i_rd_en) r_rd_word <= r_mem[i_addr];
  end

  assign o_rd_word = r_rd_word;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, address pointers and status flags in front of spi_ram_mem.
// Optional parity storage/checking is enabled with the SPI_RAM_PARITY_EN macro.
//
// Handshake: every cycle with i_rx_valid=1 is one command, no backpressure.
// o_tx_valid/o_tx_data hold until the next i_rx_valid cycle, which clears
// o_tx_valid unless that command is an accepted RD_DATA (then data updates).
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_seq_err,
  output logic       o_par_err,
  output logic       o_wr_state,
  output logic       o_rd_state
);

  spi_cmd_e             w_cmd;
  logic [DATA_W-1:0]    w_payload;
  ptr_state_e           r_wr_state, w_wr_state_nxt;
  ptr_state_e           r_rd_state, w_rd_state_nxt;
  logic                 w_wr_acc, w_rd_acc, w_rej;
  logic [ADDR_SIZE-1:0] r_wr_addr, r_rd_addr, w_mem_addr;
  logic [MEM_W-1:0]     w_wr_word, w_rd_word;
  logic                 r_tx_valid, r_seq_err;

  assign w_cmd     = spi_cmd_e'(i_rx_data[9:8]);
  assign w_payload = i_rx_data[7:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_state <= NO_ADDR;
      r_rd_state <= NO_ADDR;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_rd_state_nxt = r_rd_state;
    w_wr_acc       = 1'b0;
    w_rd_acc       = 1'b0;
    w_rej          = 1'b0;
    if (i_rx_valid) begin
      case (w_cmd)
        WR_ADDR: w_wr_state_nxt = ADDR_OK;
        RD_ADDR: w_rd_state_nxt = ADDR_OK;
        WR_DATA: begin
          w_wr_acc = (r_wr_state == ADDR_OK);
          w_rej    = (r_wr_state != ADDR_OK);
        end
        default: begin
          w_rd_acc = (r_rd_state == ADDR_OK);
          w_rej    = (r_rd_state != ADDR_OK);
        end
      endcase
    end
  end

  // Pointers are exactly log2(MEM_DEPTH) wide, so +1 wraps to 0 on its own.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_valid <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_seq_err <= w_rej;
      if (i_rx_valid) r_tx_valid <= w_rd_acc;
      if (i_rx_valid && w_cmd == WR_ADDR) r_wr_addr <= i_rx_data[ADDR_SIZE-1:0];
      else if (w_wr_acc) r_wr_addr <= r_wr_addr + 1'b1;
      if (i_rx_valid && w_cmd == RD_ADDR) r_rd_addr <= i_rx_data[ADDR_SIZE-1:0];
      else if (w_rd_acc) r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  assign w_mem_addr = w_wr_acc ? r_wr_addr : r_rd_addr;

`ifdef SPI_RAM_PARITY_EN
  logic r_par_chk, r_par_err;

  assign w_wr_word = {^w_payload, w_payload};

  // The read word lands one edge after the accepted read, so the check trails by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_par_chk <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_par_chk <= w_rd_acc;
      if (r_par_chk && (^w_rd_word)) r_par_err <= 1'b1;
    end
  end

  assign o_par_err = r_par_err;
`else
  assign w_wr_word = w_payload;
  assign o_par_err = 1'b0;
`endif

  spi_ram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE),
    .DW    (MEM_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_addr    (w_mem_addr),
    .i_wr_en   (w_wr_acc),
    .i_wr_word (w_wr_word),
    .i_rd_en   (w_rd_acc),
    .o_rd_word (w_rd_word)
  );

  assign o_tx_data  = w_rd_word[DATA_W-1:0];
  assign o_tx_valid = r_tx_valid;
  assign o_seq_err  = r_seq_err;
  assign o_wr_state = r_wr_state;
  assign o_rd_state = r_rd_state;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus random commands
// against a command-level reference model. Parity scenario needs SPI_RAM_PARITY_EN.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] i_rx_data = '0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_valid, o_seq_err, o_par_err, o_wr_state, o_rd_state;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra, exp_td;
  logic       m_wok, m_rok, exp_tv, exp_seq;

  always #5 clk = ~clk;

  spi_ram_ctrl u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_seq_err  (o_seq_err),
    .o_par_err  (o_par_err),
    .o_wr_state (o_wr_state),
    .o_rd_state (o_rd_state)
  );

  function automatic void model_reset();
    m_wa = 8'h00; m_ra = 8'h00; m_wok = 1'b0; m_rok = 1'b0;
    exp_tv = 1'b0; exp_td = 8'h00; exp_seq = 1'b0;
  endfunction

  function automatic void model_apply(logic v, logic [1:0] c, logic [7:0] p);
    exp_seq = 1'b0;
    if (v) begin
      exp_tv = 1'b0;
      case (c)
        2'd0: begin m_wa = p; m_wok = 1'b1; end
        2'd2: begin m_ra = p; m_rok = 1'b1; end
        2'd1: if (m_wok) begin m_mem[m_wa] = p; m_wa = m_wa + 8'd1; end
              else exp_seq = 1'b1;
        default: if (m_rok) begin
                   exp_td = m_mem[m_ra]; exp_tv = 1'b1; m_ra = m_ra + 8'd1;
                 end else exp_seq = 1'b1;
      endcase
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    i_rx_valid = v;
    i_rx_data  = {c, p};
    @(posedge clk);
    model_apply(v, c, p);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got %b exp 0", o_tx_valid); end
    if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %h exp 00", o_tx_data); end
    if (o_seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got %b exp 0", o_seq_err); end
    if (o_par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err got %b exp 0", o_par_err); end
    if (o_wr_state !== 1'b0) begin failures++; $display("FAIL reset_wr_state got %b exp 0", o_wr_state); end
    if (o_rd_state !== 1'b0) begin failures++; $display("FAIL reset_rd_state got %b exp 0", o_rd_state); end
  endtask

  task automatic test_fill();
    drive(1'b1, 2'd0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd1, 8'($urandom_range(0, 255)));
      checks++;
      if (o_seq_err !== 1'b0) begin failures++; $display("FAIL fill_seq_err idx %0d got %b exp 0", i, o_seq_err); end
    end
    checks++;
    if (o_wr_state !== 1'b1) begin failures++; $display("FAIL fill_wr_state got %b exp 1", o_wr_state); end
  endtask

  task automatic test_basic();
    logic seen_err = 1'b0;
    drive(1'b1, 2'd0, 8'h10); seen_err |= o_seq_err;
    drive(1'b1, 2'd1, 8'hA5); seen_err |= o_seq_err;
    drive(1'b1, 2'd2, 8'h10); seen_err |= o_seq_err;
    drive(1'b1, 2'd3, 8'h00); seen_err |= o_seq_err;
    checks += 3;
    if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL basic_tx_valid got %b exp 1", o_tx_valid); end
    if (o_tx_data !== 8'hA5) begin failures++; $display("FAIL basic_tx_data got %h exp a5", o_tx_data); end
    if (seen_err !== 1'b0) begin failures++; $display("FAIL basic_seq_err got %b exp 0", seen_err); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'd0, 8'hFF);
    drive(1'b1, 2'd1, 8'h11);
    drive(1'b1, 2'd1, 8'h22);
    drive(1'b1, 2'd2, 8'hFF);
    drive(1'b1, 2'd3, 8'h00);
    checks += 2;
    if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL wrap_first_valid got %b exp 1", o_tx_valid); end
    if (o_tx_data !== 8'h11) begin failures++; $display("FAIL wrap_first_data got %h exp 11", o_tx_data); end
    drive(1'b1, 2'd3, 8'h5A);
    checks += 2;
    if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL wrap_second_valid got %b exp 1", o_tx_valid); end
    if (o_tx_data !== 8'h22) begin failures++; $display("FAIL wrap_second_data got %h exp 22", o_tx_data); end
  endtask

  task automatic test_reject();
    do_reset();
    drive(1'b1, 2'd3, 8'h00);
    checks += 2;
    if (o_seq_err !== 1'b1) begin failures++; $display("FAIL rej_rd_seq_err got %b exp 1", o_seq_err); end
    if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL rej_rd_tx_valid got %b exp 0", o_tx_valid); end
    drive(1'b0, 2'd0, 8'h00);
    checks++;
    if (o_seq_err !== 1'b0) begin failures++; $display("FAIL rej_seq_err_pulse got %b exp 0", o_seq_err); end
    drive(1'b1, 2'd1, 8'h77);
    checks++;
    if (o_seq_err !== 1'b1) begin failures++; $display("FAIL rej_wr_seq_err got %b exp 1", o_seq_err); end
    drive(1'b1, 2'd2, 8'h00);
    drive(1'b1, 2'd3, 8'h00);
    checks += 2;
    if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL rej_mem0_valid got %b exp 1", o_tx_valid); end
    if (o_tx_data !== 8'h22) begin failures++; $display("FAIL rej_mem0_data got %h exp 22", o_tx_data); end
  endtask

  task automatic test_hold();
    drive(1'b1, 2'd0, 8'h40);
    drive(1'b1, 2'd1, 8'h3C);
    drive(1'b1, 2'd2, 8'h40);
    drive(1'b1, 2'd3, 8'h00);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 2'd1, 8'($urandom_range(0, 255)));
      checks += 2;
      if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, o_tx_valid); end
      if (o_tx_data !== 8'h3C) begin failures++; $display("FAIL hold_data cyc %0d got %h exp 3c", i, o_tx_data); end
    end
    drive(1'b1, 2'd0, 8'h00);
    checks++;
    if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL hold_drop got %b exp 0", o_tx_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd2, 8'h40);
    drive(1'b1, 2'd3, 8'h00);
    checks++;
    if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got %b exp 1", o_tx_valid); end
    do_reset();
    checks += 4;
    if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_tx_valid got %b exp 0", o_tx_valid); end
    if (o_tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data got %h exp 00", o_tx_data); end
    if (o_seq_err !== 1'b0) begin failures++; $display("FAIL mid_seq_err got %b exp 0", o_seq_err); end
    if (o_par_err !== 1'b0) begin failures++; $display("FAIL mid_par_err got %b exp 0", o_par_err); end
    drive(1'b1, 2'd3, 8'h00);
    checks += 2;
    if (o_seq_err !== 1'b1) begin failures++; $display("FAIL mid_rd_seq_err got %b exp 1", o_seq_err); end
    if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL mid_rd_valid got %b exp 0", o_tx_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      checks += 3;
      if (o_tx_valid !== exp_tv) begin failures++; $display("FAIL rand_tx_valid step %0d got %b exp %b", i, o_tx_valid, exp_tv); end
      if (exp_tv && (o_tx_data !== exp_td)) begin failures++; $display("FAIL rand_tx_data step %0d got %h exp %h", i, o_tx_data, exp_td); end
      if (o_seq_err !== exp_seq) begin failures++; $display("FAIL rand_seq_err step %0d got %b exp %b", i, o_seq_err, exp_seq); end
    end
  endtask

`ifdef SPI_RAM_PARITY_EN
  task automatic test_parity();
    drive(1'b1, 2'd0, 8'h20);
    drive(1'b1, 2'd1, 8'h5A);
    u_dut.u_mem.r_mem[8'h20][8] = ~u_dut.u_mem.r_mem[8'h20][8];
    drive(1'b1, 2'd2, 8'h20);
    drive(1'b1, 2'd3, 8'h00);
    checks++;
    if (o_tx_data !== 8'h5A) begin failures++; $display("FAIL par_tx_data got %h exp 5a", o_tx_data); end
    drive(1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'd0, 8'h00);
      checks++;
      if (o_par_err !== 1'b1) begin failures++; $display("FAIL par_sticky cyc %0d got %b exp 1", i, o_par_err); end
    end
    do_reset();
    checks++;
    if (o_par_err !== 1'b0) begin failures++; $display("FAIL par_reset got %b exp 0", o_par_err); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_basic();
    test_wrap();
    test_reject();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef SPI_RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
